// File: rtl/tlc_pkg.sv
// Shared encodings for the highway/farm-road traffic light scheduler:
// controller states and one-hot lamp codes ordered {red,yellow,green}.
package tlc_pkg;

  typedef enum logic [2:0] {
    HGRN    = 3'd0,
    HYEL    = 3'd1,
    ALLRED1 = 3'd2,
    FGRN    = 3'd3,
    FYEL    = 3'd4,
    ALLRED2 = 3'd5
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Elapsed-ticks counter for the current light phase: cleared on a phase
// change, advanced on each tick, saturating at 255.
module phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       clear,
  output logic [7:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= 8'd0;
    end else if (tick && (cnt != 8'hff)) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/tlc_scheduler.sv
// Traffic light controller for a highway crossed by a farm road, with
// vehicle sensing on the farm road and a pedestrian walk request.
module tlc_scheduler
  import tlc_pkg::*;
#(
  parameter int HWY_MIN_GREEN  = 10,
  parameter int FARM_MIN_GREEN = 3,
  parameter int FARM_MAX_GREEN = 10,
  parameter int YELLOW_TIME    = 3,
  parameter int ALLRED_TIME    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       car_farm,
  input  logic       ped_req,
  output logic [2:0] light_highway,
  output logic [2:0] light_farm,
  output logic       ped_walk,
  output logic [2:0] phase
);

  // Thresholds are "last tick of the phase" values, pre-sized to cnt's width.
  localparam logic [7:0] HWY_LAST      = 8'(HWY_MIN_GREEN - 1);
  localparam logic [7:0] FARM_MIN_LAST = 8'(FARM_MIN_GREEN - 1);
  localparam logic [7:0] FARM_MAX_LAST = 8'(FARM_MAX_GREEN - 1);
  localparam logic [7:0] YEL_LAST      = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] ALLRED_LAST   = 8'(ALLRED_TIME - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] cnt;
  logic       state_change;
  logic       ped_pending;
  logic [2:0] hw_nxt;
  logic [2:0] farm_nxt;

  assign state_change = (next_state != state);
  assign phase        = state;

  phase_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .clear (state_change),
    .cnt   (cnt)
  );

  always_comb begin
    next_state = state;
    case (state)
      HGRN:    if (tick && (cnt >= HWY_LAST) && (car_farm || ped_pending)) next_state = HYEL;
      HYEL:    if (tick && (cnt == YEL_LAST))    next_state = ALLRED1;
      ALLRED1: if (tick && (cnt == ALLRED_LAST)) next_state = FGRN;
      FGRN:    if (tick && (((cnt >= FARM_MIN_LAST) && !car_farm) || (cnt == FARM_MAX_LAST)))
                 next_state = FYEL;
      FYEL:    if (tick && (cnt == YEL_LAST))    next_state = ALLRED2;
      ALLRED2: if (tick && (cnt == ALLRED_LAST)) next_state = HGRN;
      default: next_state = ALLRED1;
    endcase
  end

  // Lamps are decoded from the next state so the registered outputs line up
  // with the state register; any unexpected code shows red both ways.
  always_comb begin
    hw_nxt   = RED;
    farm_nxt = RED;
    case (next_state)
      HGRN:    hw_nxt   = GRN;
      HYEL:    hw_nxt   = YEL;
      FGRN:    farm_nxt = GRN;
      FYEL:    farm_nxt = YEL;
      default: begin
        hw_nxt   = RED;
        farm_nxt = RED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HGRN;
      ped_pending   <= 1'b0;
      ped_walk      <= 1'b0;
      light_highway <= GRN;
      light_farm    <= RED;
    end else begin
      state         <= next_state;
      light_highway <= hw_nxt;
      light_farm    <= farm_nxt;
      if (ped_req) begin
        ped_pending <= 1'b1;
      end else if ((state == ALLRED1) && (next_state == FGRN)) begin
        ped_pending <= 1'b0;
      end
      // Walk is latched from the pending flag on FGRN entry and held for the phase.
      if (next_state == FGRN) begin
        ped_walk <= (state == FGRN) ? ped_walk : ped_pending;
      end else begin
        ped_walk <= 1'b0;
      end
    end
  end

endmodule
